sample_streamer: RTL and testbench

//   Producer side of the filter's sample interface (din_enable / datain).

---
 rtl/sample_streamer.sv | 147 ++++++++++++++
 tb/tb_sample_streamer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_streamer.sv
// Rate-paced sample producer: a host-filled FIFO drained into the filter
// with one din_enable strobe every PERIOD clocks.
module sample_streamer #(
  parameter int DEPTH  = 16,
  parameter int PERIOD = 256,
  parameter int AW     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic signed [15:0] wr_data,
  input  logic               start,
  input  logic               stop,
  output logic               din_enable,
  output logic signed [15:0] datain,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        level,
  output logic               overflow,
  output logic               underrun,
  output logic               busy
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW:0]        level_reg;
  logic signed [15:0] mem [DEPTH];

  logic tick;
  logic has_data;
  logic pop;
  logic push;

  // Pops look only at the registered level, so a write landing in an empty
  // FIFO on a tick cycle waits for the next tick.
  assign tick     = (state_reg != IDLE) && (count_reg == CNT_LAST);
  assign has_data = (level_reg != '0);
  assign pop      = tick && has_data;
  assign full     = (level_reg == LVL_FULL);
  assign empty    = !has_data;
  assign push     = wr_en && (!full || pop);

  assign level = level_reg;
  assign busy  = (state_reg != IDLE);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_ONE;
        2'b01:   level_reg <= level_reg - LVL_ONE;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Sequencer: the pacing counter, state and every filter-facing output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      din_enable <= 1'b0;
      datain     <= '0;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      din_enable <= 1'b0;

      if (state_reg == IDLE || tick) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + CNT_ONE;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            overflow  <= 1'b0;
            underrun  <= 1'b0;
          end
        end
        RUN: begin
          if (tick) begin
            din_enable <= 1'b1;
            if (has_data) begin
              datain <= mem[rd_ptr_reg];
            end else begin
              datain   <= '0;
              underrun <= 1'b1;
            end
          end
          if (stop) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // An empty tick ends the drain silently; it is never zero-stuffed.
          if (tick) begin
            if (has_data) begin
              din_enable <= 1'b1;
              datain     <= mem[rd_ptr_reg];
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (wr_en && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_streamer.sv
// Directed bench for sample_streamer with PERIOD=8, DEPTH=16: table-driven
// fill/pulse vectors plus hand sequences for stop, drain and reset cases.
module tb_sample_streamer;
  localparam int DEPTH  = 16;
  localparam int PERIOD = 8;
  localparam int AW     = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [15:0]   wr_data;
  logic          start;
  logic          stop;
  logic          din_enable;
  logic [15:0]   datain;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          underrun;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  typedef struct {
    logic [15:0] data;
    int          lvl;
    logic        fl;
    logic        ovf;
  } fill_vec_t;

  typedef struct {
    logic [15:0] data;
    logic        und;
    int          lvl;
  } pulse_vec_t;

  fill_vec_t  fv [17];
  pulse_vec_t pv [4];

  sample_streamer #(.DEPTH(DEPTH), .PERIOD(PERIOD), .AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .start      (start),
    .stop       (stop),
    .din_enable (din_enable),
    .datain     (datain),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("check %s = 0x%0h", name, act);
    end
  endtask

  task automatic write_sample(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_start(output int at);
    start = 1'b1;
    tick();
    start = 1'b0;
    at = cycle;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_pulse(input string name, output int at);
    at = -1;
    for (int n = 0; n < 2 * PERIOD + 4; n++) begin
      tick();
      if (din_enable === 1'b1) begin
        at = cycle;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s actual=no_pulse required=pulse_within_%0d_cycles", name, 2 * PERIOD + 4);
  endtask

  // Runs past the next tick and reports how many strobes appeared.
  task automatic idle_window(output int pulses);
    pulses = 0;
    for (int n = 0; n < PERIOD + 1; n++) begin
      tick();
      if (din_enable === 1'b1) pulses++;
    end
  endtask

  initial begin
    int s_at;
    int p_at;
    int prev;
    int extra;

    for (int i = 0; i < 17; i++) begin
      fv[i].data = 16'h1000 + 16'(i);
      fv[i].lvl  = (i < 16) ? i + 1 : 16;
      fv[i].fl   = (i >= 15);
      fv[i].ovf  = (i == 16);
    end
    pv[0] = '{16'h0003, 1'b0, 2};
    pv[1] = '{16'hFFFB, 1'b0, 1};
    pv[2] = '{16'h0007, 1'b0, 0};
    pv[3] = '{16'h0000, 1'b1, 0};

    reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; stop = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    // 1: asynchronous reset in the middle of a cycle with a pulse showing
    write_sample(16'h0064);
    write_sample(16'h00C8);
    chk("t1_level_2", 32'(level), 2);
    do_start(s_at);
    wait_pulse("t1_pulse", p_at);
    chk("t1_latency", p_at - s_at, PERIOD);
    chk("t1_datain", 32'(datain), 32'h64);
    chk("t1_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("t1_rst_den", 32'(din_enable), 0);
    chk("t1_rst_datain", 32'(datain), 0);
    chk("t1_rst_level", 32'(level), 0);
    chk("t1_rst_empty", 32'(empty), 1);
    chk("t1_rst_busy", 32'(busy), 0);
    chk("t1_rst_ovf", 32'(overflow), 0);
    chk("t1_rst_und", 32'(underrun), 0);
    tick();
    reset = 1'b0;

    // 2: three samples then one zero-stuffed underrun pulse
    write_sample(16'h0003);
    write_sample(16'hFFFB);
    write_sample(16'h0007);
    do_start(s_at);
    prev = s_at;
    for (int i = 0; i < 4; i++) begin
      wait_pulse($sformatf("t2_pulse%0d", i), p_at);
      chk($sformatf("t2_spacing%0d", i), p_at - prev, PERIOD);
      chk($sformatf("t2_datain%0d", i), 32'(datain), 32'(pv[i].data));
      chk($sformatf("t2_underrun%0d", i), 32'(underrun), 32'(pv[i].und));
      chk($sformatf("t2_level%0d", i), 32'(level), pv[i].lvl);
      prev = p_at;
      tick();
      chk($sformatf("t2_den_low%0d", i), 32'(din_enable), 0);
    end
    do_stop();
    idle_window(extra);
    chk("t2_no_drain_pulse", extra, 0);
    chk("t2_busy_off", 32'(busy), 0);

    // 3: overfill while idle; the 17th write is dropped
    for (int i = 0; i < 17; i++) begin
      write_sample(fv[i].data);
      chk($sformatf("t3_level%0d", i), 32'(level), fv[i].lvl);
      chk($sformatf("t3_full%0d", i), 32'(full), 32'(fv[i].fl));
      chk($sformatf("t3_ovf%0d", i), 32'(overflow), 32'(fv[i].ovf));
    end
    chk("t3_und_sticky", 32'(underrun), 1);

    // 4: write into a full FIFO on the tick cycle, then drain it all
    do_start(s_at);
    chk("t4_ovf_cleared", 32'(overflow), 0);
    chk("t4_und_cleared", 32'(underrun), 0);
    repeat (PERIOD - 1) tick();
    chk("t4_level_pre", 32'(level), 16);
    write_sample(16'h2222);
    chk("t4_tick_den", 32'(din_enable), 1);
    chk("t4_tick_datain", 32'(datain), 32'h1000);
    chk("t4_level_kept", 32'(level), 16);
    chk("t4_ovf_kept", 32'(overflow), 0);
    prev = cycle;
    do_stop();
    chk("t4_den_low", 32'(din_enable), 0);
    for (int j = 0; j < 16; j++) begin
      wait_pulse($sformatf("t4_pulse%0d", j), p_at);
      chk($sformatf("t4_spacing%0d", j), p_at - prev, PERIOD);
      chk($sformatf("t4_datain%0d", j), 32'(datain),
          (j < 15) ? 32'(16'h1001 + 16'(j)) : 32'h2222);
      prev = p_at;
    end
    idle_window(extra);
    chk("t4_no_extra", extra, 0);
    chk("t4_busy_off", 32'(busy), 0);
    chk("t4_und_zero", 32'(underrun), 0);
    chk("t4_empty", 32'(empty), 1);

    // 5: stop before the first tick drains exactly two samples
    write_sample(16'h0055);
    write_sample(16'h00AA);
    do_start(s_at);
    do_stop();
    chk("t5_busy_drain", 32'(busy), 1);
    wait_pulse("t5_pulse0", p_at);
    chk("t5_spacing0", p_at - s_at, PERIOD);
    chk("t5_datain0", 32'(datain), 32'h55);
    prev = p_at;
    wait_pulse("t5_pulse1", p_at);
    chk("t5_spacing1", p_at - prev, PERIOD);
    chk("t5_datain1", 32'(datain), 32'hAA);
    idle_window(extra);
    chk("t5_no_zero_pulse", extra, 0);
    chk("t5_busy_off", 32'(busy), 0);
    chk("t5_und_zero", 32'(underrun), 0);
    chk("t5_datain_hold", 32'(datain), 32'hAA);

    // 6: reset with five queued, then restart yields only stuffed zeros
    for (int i = 0; i < 6; i++) write_sample(16'h6000 + 16'(i));
    do_start(s_at);
    wait_pulse("t6_pulse_pre", p_at);
    chk("t6_datain_pre", 32'(datain), 32'h6000);
    chk("t6_level_5", 32'(level), 5);
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_level", 32'(level), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    tick();
    reset = 1'b0;
    do_start(s_at);
    prev = s_at;
    for (int i = 0; i < 2; i++) begin
      wait_pulse($sformatf("t6_pulse%0d", i), p_at);
      chk($sformatf("t6_spacing%0d", i), p_at - prev, PERIOD);
      chk($sformatf("t6_datain%0d", i), 32'(datain), 0);
      chk($sformatf("t6_underrun%0d", i), 32'(underrun), 1);
      prev = p_at;
    end
    do_stop();
    idle_window(extra);
    chk("t6_busy_off", 32'(busy), 0);
    chk("t6_level_end", 32'(level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
